sevenseg_sr_chain_driver: RTL and testbench

Parametrised 7-segment display driver that accepts a magnitude/sign/error result over a valid-ready handshake and serialises it into a chain of 74HC595-style shift registers, one 8-bit register per digit (segments a–g plus decimal point). It sits between the calculator datapath and the board-level display chain. It adds decimal-point control, a fully registered divided shift clock, segment polarity selection and PWM brightness on output-enable.

---
 rtl/sevenseg_sr_chain_driver.sv | 178 +++++++++++++++++
 tb/tb_sevenseg_sr_chain_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_sr_chain_driver.sv
`default_nettype none
// sevenseg_sr_chain_driver: serialises a hex/sign/error result into a chain of
// 74HC595 digit registers with a divided shift clock and PWM output-enable dimming.
module sevenseg_sr_chain_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_DIGITS     = 5,
    parameter int CLK_DIV        = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_is_neg,
    input  logic                  i_error,
    input  logic [NUM_DIGITS-1:0] i_dp_mask,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_brightness,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch,
    output logic                  o_sr_oe_n
);
    localparam int   FW  = NUM_DIGITS * 8;
    localparam int   PW  = (DATA_WIDTH > 4 * NUM_DIGITS) ? DATA_WIDTH : 4 * NUM_DIGITS;
    localparam int   BW  = $clog2(FW);
    localparam int   DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic POL = (SEG_ACTIVE_LOW != 0);

    // Segment pattern ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Byte k of the frame is digit k as {a..g,dp}; the MSB is shifted out first.
    function automatic logic [FW-1:0] build_frame(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  neg,
        input logic                  err,
        input logic [NUM_DIGITS-1:0] dp
    );
        logic [PW-1:0] pad;
        logic [6:0]    seg;
        logic [FW-1:0] f;
        int            hi;
        int            sgn;
        pad = PW'(d);
        hi  = 0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (pad[4*k +: 4] != 4'h0) hi = k;
        sgn = (hi + 1 > NUM_DIGITS - 1) ? NUM_DIGITS - 1 : hi + 1;
        f   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (err) begin
                seg = (k == 2) ? 7'b1001111 : ((k < 2) ? 7'b0000101 : 7'b0000000);
                f[8*k +: 8] = {seg, 1'b0};
            end else begin
                if (neg && k == sgn)
                    seg = 7'b0000001;
                else if (k > hi)
                    seg = 7'b0000000;
                else
                    seg = hex_seg(pad[4*k +: 4]);
                f[8*k +: 8] = {seg, dp[k]};
            end
        end
        return f;
    endfunction

    localparam logic [FW-1:0] ZERO_FRAME = build_frame('0, 1'b0, 1'b0, '0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] frame;
    logic [FW-1:0] new_frame;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [3:0]    pwm_cnt;
    logic          half;
    logic          tick;
    logic          last_bit;

    assign new_frame = build_frame(i_data, i_is_neg, i_error, i_dp_mask);
    assign tick      = (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BW'(FW - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = SHIFT;
            SHIFT:   if (tick && half && last_bit) state_next = LATCH;
            LATCH:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SHIFT;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset behaves as an accept of an all-zero result: bit 0 already on the line.
            frame      <= ZERO_FRAME << 1;
            o_sr_data  <= ZERO_FRAME[FW-1] ^ POL;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            half       <= 1'b0;
            pwm_cnt    <= 4'd0;
            o_sr_clk   <= 1'b0;
            o_sr_latch <= 1'b0;
            o_sr_oe_n  <= 1'b1;
            o_ready    <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 4'd1;
            o_ready    <= (state_next == IDLE);
            o_sr_latch <= (state_next == LATCH);
            o_sr_oe_n  <= !((state_next == IDLE) && (pwm_cnt <= i_brightness));
            div_cnt    <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        frame     <= {new_frame[FW-2:0], 1'b0};
                        o_sr_data <= new_frame[FW-1] ^ POL;
                        bit_cnt   <= '0;
                        half      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        half <= !half;
                        if (!half) begin
                            o_sr_clk <= 1'b1;
                        end else begin
                            o_sr_clk <= 1'b0;
                            if (last_bit) begin
                                o_sr_data <= POL;
                            end else begin
                                o_sr_data <= frame[FW-1] ^ POL;
                                frame     <= frame << 1;
                                bit_cnt   <= bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_sr_chain_driver.sv
`default_nettype none
// Directed bench for sevenseg_sr_chain_driver: two parameter sets, frames captured
// on shift-clock rising edges and compared against hand-encoded segment bytes.
module tb_sevenseg_sr_chain_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_data;
    logic        a_neg, a_err, a_valid;
    logic [4:0]  a_dp;
    logic [3:0]  a_bright;
    logic        a_ready, a_sd, a_sc, a_sl, a_oe;

    logic [19:0] b_data;
    logic        b_neg, b_err, b_valid;
    logic [4:0]  b_dp;
    logic [3:0]  b_bright;
    logic        b_ready, b_sd, b_sc, b_sl, b_oe;

    int n_vec  = 0;
    int n_miss = 0;

    sevenseg_sr_chain_driver #(
        .DATA_WIDTH(16), .NUM_DIGITS(5), .CLK_DIV(2), .SEG_ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .i_data(a_data), .i_is_neg(a_neg), .i_error(a_err),
        .i_dp_mask(a_dp), .i_valid(a_valid), .o_ready(a_ready), .i_brightness(a_bright),
        .o_sr_data(a_sd), .o_sr_clk(a_sc), .o_sr_latch(a_sl), .o_sr_oe_n(a_oe)
    );

    sevenseg_sr_chain_driver #(
        .DATA_WIDTH(20), .NUM_DIGITS(5), .CLK_DIV(1), .SEG_ACTIVE_LOW(1)
    ) u_dut_alt (
        .clk(clk), .rst_n(rst_n), .i_data(b_data), .i_is_neg(b_neg), .i_error(b_err),
        .i_dp_mask(b_dp), .i_valid(b_valid), .o_ready(b_ready), .i_brightness(b_bright),
        .o_sr_data(b_sd), .o_sr_clk(b_sc), .o_sr_latch(b_sl), .o_sr_oe_n(b_oe)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Collects one frame, starting just after an accept edge or reset release.
    task automatic run_frame(input bit use_b, input bit wiggle, input int cd,
                             output logic [39:0] bits, output int cyc, output int nbits,
                             output int nlatch, output int oe_bad, output int clk_bad);
        logic prev, sc, sd, sl, oe, rdy;
        int   hi_run;
        bits = '0; cyc = 0; nbits = 0; nlatch = 0; oe_bad = 0; clk_bad = 0;
        prev = 1'b0; rdy = 1'b0; hi_run = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            sc  = use_b ? b_sc    : a_sc;
            sd  = use_b ? b_sd    : a_sd;
            sl  = use_b ? b_sl    : a_sl;
            oe  = use_b ? b_oe    : a_oe;
            rdy = use_b ? b_ready : a_ready;
            if (rdy) begin
                if (wiggle) a_valid = 1'b0;
                break;
            end
            if (sc && !prev) begin
                bits = {bits[38:0], sd};
                nbits++;
            end
            if (sc) hi_run++;
            else begin
                if (prev && hi_run != cd) clk_bad++;
                hi_run = 0;
            end
            if (sl) begin
                nlatch++;
                if (sc) clk_bad++;
            end
            if (!oe) oe_bad++;
            prev = sc;
            if (wiggle) begin
                a_data  = 16'($urandom);
                a_valid = 1'b1;
            end
        end
        if (!rdy) cyc = -1;
    endtask

    task automatic send_a(input logic [15:0] d, input logic neg, input logic err, input logic [4:0] dp);
        a_data = d; a_neg = neg; a_err = err; a_dp = dp; a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [19:0] d, input logic neg, input logic err, input logic [4:0] dp);
        b_data = d; b_neg = neg; b_err = err; b_dp = dp; b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
    endtask

    task automatic do_frame_a(input string tag, input logic [15:0] d, input logic neg,
                              input logic err, input logic [4:0] dp, input bit wiggle,
                              input logic [39:0] exp);
        logic [39:0] bits;
        int cyc, nb, nl, ob, cb;
        send_a(d, neg, err, dp);
        run_frame(1'b0, wiggle, 2, bits, cyc, nb, nl, ob, cb);
        check_value({tag, "_frame"}, 64'(bits), 64'(exp));
        check_value({tag, "_cycles"}, 64'(cyc), 64'(163));
        check_value({tag, "_oe_busy"}, 64'(ob), 64'(0));
        check_value({tag, "_clk_phase"}, 64'(cb), 64'(0));
    endtask

    initial begin
        logic [39:0] bits;
        int cyc, nb, nl, ob, cb, lows;

        rst_n = 1'b0;
        a_data = '0; a_neg = 1'b0; a_err = 1'b0; a_dp = '0; a_valid = 1'b0; a_bright = 4'd15;
        b_data = '0; b_neg = 1'b0; b_err = 1'b0; b_dp = '0; b_valid = 1'b0; b_bright = 4'd0;
        repeat (3) @(negedge clk);
        check_value("reset_outs", 64'({a_sc, a_sl, a_oe, a_sd, a_ready}), 64'(5'b00100));

        rst_n = 1'b1;
        run_frame(1'b0, 1'b0, 2, bits, cyc, nb, nl, ob, cb);
        check_value("pwr_frame", 64'(bits), 64'(40'h00_00_00_00_FC));
        check_value("pwr_cycles", 64'(cyc), 64'(162));
        check_value("pwr_bits", 64'(nb), 64'(40));
        check_value("pwr_latch", 64'(nl), 64'(2));
        check_value("pwr_oe_busy", 64'(ob), 64'(0));
        check_value("pwr_clk_phase", 64'(cb), 64'(0));

        do_frame_a("a3_pos",   16'h00A3, 1'b0, 1'b0, 5'b00000, 1'b0, 40'h00_00_00_EE_F2);
        do_frame_a("a3_neg",   16'h00A3, 1'b1, 1'b0, 5'b00000, 1'b0, 40'h00_00_02_EE_F2);
        do_frame_a("a3_dp",    16'h00A3, 1'b0, 1'b0, 5'b10001, 1'b0, 40'h01_00_00_EE_F3);
        do_frame_a("zero_neg", 16'h0000, 1'b1, 1'b0, 5'b00000, 1'b0, 40'h00_00_00_02_FC);
        do_frame_a("ffff_neg", 16'hFFFF, 1'b1, 1'b0, 5'b00000, 1'b0, 40'h02_8E_8E_8E_8E);
        do_frame_a("err",      16'h1234, 1'b1, 1'b1, 5'b11111, 1'b0, 40'h00_00_9E_0A_0A);
        do_frame_a("busy",     16'h00A3, 1'b0, 1'b0, 5'b00000, 1'b1, 40'h00_00_00_EE_F2);

        a_bright = 4'd3;
        lows = 0;
        repeat (32) begin @(negedge clk); if (!a_oe) lows++; end
        check_value("bright3_lows", 64'(lows), 64'(8));
        a_bright = 4'd15;
        lows = 0;
        repeat (32) begin @(negedge clk); if (!a_oe) lows++; end
        check_value("bright15_lows", 64'(lows), 64'(32));
        a_bright = 4'd0;
        lows = 0;
        repeat (32) begin @(negedge clk); if (!a_oe) lows++; end
        check_value("bright0_lows", 64'(lows), 64'(2));

        send_a(16'h00A3, 1'b0, 1'b0, 5'b00000);
        repeat (71) @(negedge clk);
        check_value("abort_pre_clk", 64'(a_sc), 64'(1));
        rst_n = 1'b0;
        #1;
        check_value("abort_outs", 64'({a_sc, a_sl, a_oe, a_sd, a_ready}), 64'(5'b00100));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 1'b0, 2, bits, cyc, nb, nl, ob, cb);
        check_value("abort_frame", 64'(bits), 64'(40'h00_00_00_00_FC));
        check_value("abort_cycles", 64'(cyc), 64'(162));

        check_value("alt_idle_data", 64'(b_sd), 64'(1));
        check_value("alt_idle_ready", 64'(b_ready), 64'(1));
        send_b(20'hF1234, 1'b1, 1'b0, 5'b00000);
        run_frame(1'b1, 1'b0, 1, bits, cyc, nb, nl, ob, cb);
        check_value("alt_neg_frame", 64'(bits), 64'(40'hFD_9F_25_0D_99));
        check_value("alt_neg_cycles", 64'(cyc), 64'(82));
        check_value("alt_neg_latch", 64'(nl), 64'(1));
        send_b(20'h00A3, 1'b1, 1'b1, 5'b11111);
        run_frame(1'b1, 1'b0, 1, bits, cyc, nb, nl, ob, cb);
        check_value("alt_err_frame", 64'(bits), 64'(40'hFF_FF_61_F5_F5));
        check_value("alt_err_cycles", 64'(cyc), 64'(82));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
